bram_port_arbiter: RTL and testbench

//   Two-requester arbiter for a single synchronous-read port of the shared bram block.

---
 rtl/bram_port_arbiter.sv | 91 +++++++++
 tb/tb_bram_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for one synchronous-read bram port, with per-requester lock and read-data steering.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention; otherwise requester 0 has fixed priority.
module bram_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {NONE, OWN0, OWN1} owner_t;

  owner_t owner_q, owner_d;
  logic   rvalid0_q, rvalid0_d;
  logic   rvalid1_q, rvalid1_d;
  logic   elig0, elig1;
  logic   win0, win1;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_winner_q, last_winner_d;
`endif

  always_comb begin
    // A locked owner shuts the other requester out until its lock drops.
    elig0 = req0 & ~((owner_q == OWN1) & lock1);
    elig1 = req1 & ~((owner_q == OWN0) & lock0);
`ifdef ARB_ROUND_ROBIN_EN
    win0 = elig0 & (~elig1 | last_winner_q);
    win1 = elig1 & (~elig0 | ~last_winner_q);
`else
    win0 = elig0;
    win1 = elig1 & ~elig0;
`endif
    gnt0     = win0 & ~reset;
    gnt1     = win1 & ~reset;
    mem_addr = win1 ? addr1 : addr0;
    mem_data = win1 ? wdata1 : wdata0;
    mem_we   = (gnt0 & we0) | (gnt1 & we1);

    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    if (win0)      owner_d = lock0 ? OWN0 : NONE;
    else if (win1) owner_d = lock1 ? OWN1 : NONE;
    else           owner_d = NONE;
`ifdef ARB_ROUND_ROBIN_EN
    last_winner_d = win1 ? 1'b1 : (win0 ? 1'b0 : last_winner_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= NONE;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_winner_q <= 1'b1;
`endif
    end else begin
      owner_q   <= owner_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_winner_q <= last_winner_d;
`endif
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = mem_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a write-first synchronous bram model on the port.
// Expectations follow ARB_ROUND_ROBIN_EN when the bench is built with it defined.
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [9:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic [15:0] mem_q;

  logic [15:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_data;
      mem_q         <= mem_data;
    end else begin
      mem_q <= mem[mem_addr];
    end
  end

  bram_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_q(mem_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic l0, input logic [9:0] a0,
                       input logic [15:0] d0, input logic r1, input logic w1, input logic l1,
                       input logic [9:0] a1, input logic [15:0] d1);
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic to_sample;
    @(negedge clk);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic g0, input logic g1);
    chk({tag, "_gnt0"}, {31'd0, gnt0}, {31'd0, g0});
    chk({tag, "_gnt1"}, {31'd0, gnt1}, {31'd0, g1});
    $display("step %s gnt0=%b gnt1=%b rvalid0=%b rvalid1=%b rdata=%h mem_we=%b mem_addr=%h",
             tag, gnt0, gnt1, rvalid0, rvalid1, rdata, mem_we, mem_addr);
  endtask

  task automatic chk_rv(input string tag, input logic v0, input logic v1, input logic [15:0] d);
    chk({tag, "_rvalid0"}, {31'd0, rvalid0}, {31'd0, v0});
    chk({tag, "_rvalid1"}, {31'd0, rvalid1}, {31'd0, v1});
    if (v0 | v1) chk({tag, "_rdata"}, {16'd0, rdata}, {16'd0, d});
  endtask

  logic e0, e1, pv0, pv1;

  initial begin
    // 1: reset with both requesters active
    reset = 1'b1;
    drive(1, 1, 0, 10'h000, 16'h1234, 1, 1, 0, 10'h001, 16'h5678);
    for (int i = 0; i < 2; i++) begin
      to_sample;
      chk_gnt("reset", 0, 0);
      chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
      chk_rv("reset", 0, 0, 16'h0);
      next_cycle;
    end

    // 2: write then read by requester 0
    reset = 1'b0;
    drive(1, 1, 0, 10'h000, 16'h000F, 0, 0, 0, 10'h000, 16'h0);
    to_sample;
    chk_gnt("wr0", 1, 0);
    chk("wr0_mem_we", {31'd0, mem_we}, 32'd1);
    chk("wr0_mem_data", {16'd0, mem_data}, 32'h000F);
    next_cycle;
    drive(1, 0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0);
    to_sample;
    chk_gnt("rd0", 1, 0);
    chk("rd0_mem_we", {31'd0, mem_we}, 32'd0);
    chk_rv("rd0_after_wr", 0, 0, 16'h0);
    next_cycle;
    drive(0, 0, 0, 10'h155, 16'h0, 0, 0, 0, 10'h2AA, 16'h0);
    to_sample;
    chk_gnt("idle", 0, 0);
    chk("idle_mem_addr", {22'd0, mem_addr}, 32'h155);
    chk_rv("rd0_data", 1, 0, 16'h000F);
    next_cycle;

    // preload for contention, then reset to restore last_winner
    drive(1, 1, 0, 10'h001, 16'h00F0, 0, 0, 0, 10'h000, 16'h0);
    to_sample; chk_gnt("pre1", 1, 0); next_cycle;
    drive(1, 1, 0, 10'h003, 16'h0C00, 0, 0, 0, 10'h000, 16'h0);
    to_sample; chk_gnt("pre3", 1, 0); next_cycle;
    drive(0, 0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0);
    reset = 1'b1;
    next_cycle;
    reset = 1'b0;

    // 3: both requesters read every cycle
    drive(1, 0, 0, 10'h001, 16'h0, 1, 0, 0, 10'h003, 16'h0);
    pv0 = 0; pv1 = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      e0 = (k % 2 == 0); e1 = (k % 2 == 1);
`else
      e0 = 1'b1; e1 = 1'b0;
`endif
      to_sample;
      chk_gnt($sformatf("cont%0d", k), e0, e1);
      chk_rv($sformatf("cont%0d", k), pv0, pv1, pv0 ? 16'h00F0 : 16'h0C00);
      pv0 = e0; pv1 = e1;
      next_cycle;
    end
    drive(0, 0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0);
    to_sample;
    chk_rv("cont_tail", pv0, pv1, pv0 ? 16'h00F0 : 16'h0C00);
    next_cycle;

    // 4: locked reads by requester 0 hold off requester 1
    drive(1, 0, 1, 10'h001, 16'h0, 1, 0, 0, 10'h003, 16'h0);
    for (int k = 0; k < 3; k++) begin
      to_sample; chk_gnt($sformatf("lock%0d", k), 1, 0); next_cycle;
    end
    drive(0, 0, 0, 10'h001, 16'h0, 1, 0, 0, 10'h003, 16'h0);
    to_sample;
    chk_gnt("unlock", 0, 1);
    chk_rv("unlock", 1, 0, 16'h00F0);
    next_cycle;
    drive(0, 0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0);
    to_sample; chk_rv("unlock_rd1", 0, 1, 16'h0C00); next_cycle;

    // lock held with request dropped: no grant, ownership released next edge
    drive(1, 0, 1, 10'h001, 16'h0, 0, 0, 0, 10'h000, 16'h0);
    to_sample; chk_gnt("lk_take", 1, 0); next_cycle;
    drive(0, 0, 1, 10'h001, 16'h0, 1, 0, 0, 10'h003, 16'h0);
    to_sample; chk_gnt("lk_noreq", 0, 0); next_cycle;
    to_sample; chk_gnt("lk_released", 0, 1); next_cycle;
    drive(0, 0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0);
    next_cycle;

    // 5: requester 1 at the top address
    drive(0, 0, 0, 10'h000, 16'h0, 1, 1, 0, 10'h3FF, 16'h3FFF);
    to_sample;
    chk_gnt("wr1", 0, 1);
    chk("wr1_mem_addr", {22'd0, mem_addr}, 32'h3FF);
    chk("wr1_mem_we", {31'd0, mem_we}, 32'd1);
    next_cycle;
    drive(0, 0, 0, 10'h000, 16'h0, 1, 0, 0, 10'h3FF, 16'h0);
    to_sample; chk_gnt("rd1_top", 0, 1); chk_rv("rd1_top_req", 0, 0, 16'h0); next_cycle;
    drive(0, 0, 0, 10'h000, 16'h0, 1, 0, 0, 10'h000, 16'h0);
    to_sample; chk_gnt("rd1_zero", 0, 1); chk_rv("rd1_top", 0, 1, 16'h3FFF); next_cycle;
    drive(0, 0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0);
    to_sample; chk_rv("rd1_zero", 0, 1, 16'h000F); next_cycle;

    // 6: reset in the grant cycle of a locked read by requester 1
    drive(0, 0, 0, 10'h000, 16'h0, 1, 0, 1, 10'h003, 16'h0);
    to_sample; chk_gnt("rst_pre", 0, 1); next_cycle;
    reset = 1'b1;
    drive(1, 0, 0, 10'h001, 16'h0, 1, 0, 1, 10'h003, 16'h0);
    to_sample;
    chk_gnt("rst_grant", 0, 0);
    chk("rst_grant_mem_we", {31'd0, mem_we}, 32'd0);
    chk_rv("rst_prev_rd", 0, 1, 16'h0C00);
    next_cycle;
    reset = 1'b0;
    drive(1, 0, 0, 10'h001, 16'h0, 0, 0, 1, 10'h003, 16'h0);
    to_sample;
    chk_rv("rst_after", 0, 0, 16'h0);
    chk_gnt("rst_owner_none", 1, 0);
    next_cycle;
    drive(0, 0, 0, 10'h000, 16'h0, 0, 0, 0, 10'h000, 16'h0);
    to_sample; chk_rv("rst_final", 1, 0, 16'h00F0); next_cycle;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
